// File: rtl/flatten_node_list_pkg.sv
// Shared constants for the node-list flattening stage: RAM word field
// positions, descriptor layout and the controller state encoding.
package flatten_node_list_pkg;

  // nodeHeads word: [63] valid, [4:0] head link index
  localparam int VALID_BIT     = 63;
  // nodeToElement word: [63] has_next, [36:32] element, [4:0] next link
  localparam int HAS_NEXT_BIT  = 63;
  localparam int ELEM_LSB      = 32;
  localparam int PTR_LSB       = 0;

  localparam int OFS_START_LSB = 0;
  localparam int OFS_START_W   = 6;
  localparam int OFS_COUNT_LSB = 16;
  localparam int OFS_COUNT_W   = 6;
  localparam int OFS_OVF_BIT   = 31;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_H_ADDR = 4'd1,
    S_H_WAIT = 4'd2,
    S_H_EVAL = 4'd3,
    S_L_ADDR = 4'd4,
    S_L_WAIT = 4'd5,
    S_L_EVAL = 4'd6,
    S_OFS_WR = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  function automatic logic [31:0] pack_offset(
    input logic [OFS_START_W-1:0] start,
    input logic [OFS_COUNT_W-1:0] count,
    input logic                   ovf
  );
    logic [31:0] w;
    w = '0;
    w[OFS_START_LSB +: OFS_START_W] = start;
    w[OFS_COUNT_LSB +: OFS_COUNT_W] = count;
    w[OFS_OVF_BIT]                  = ovf;
    return w;
  endfunction

endpackage

// File: rtl/flatten_node_list_controller.sv
// Sequencing FSM for the flattening walk: head fetch, link chase,
// descriptor write, with loop-guard and capacity exits.
module flatten_node_list_controller
  import flatten_node_list_pkg::*;
(
  input  logic   clk,
  input  logic   i_program_reset,
  input  logic   i_start_process,
  input  logic   i_start_rise,
  input  logic   i_num_nodes_zero,
  input  logic   i_head_valid,
  input  logic   i_has_next,
  input  logic   i_guard_hit,
  input  logic   i_cap_hit,
  input  logic   i_last_node,
  input  logic   i_cap_abort,
  output state_t o_cs,
  output state_t o_ns,
  output logic   o_adj_wren,
  output logic   o_ofs_wren
);

  state_t r_cs;
  state_t w_ns;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (i_program_reset) r_cs <= S_IDLE;
    else                 r_cs <= w_ns;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ns       = r_cs;
    o_adj_wren = 1'b0;
    o_ofs_wren = 1'b0;
    case (r_cs)
      S_IDLE: begin
        if (i_start_rise) w_ns = i_num_nodes_zero ? S_DONE : S_H_ADDR;
      end
      S_H_ADDR: w_ns = S_H_WAIT;
      S_H_WAIT: w_ns = S_H_EVAL;
      S_H_EVAL: w_ns = i_head_valid ? S_L_ADDR : S_OFS_WR;
      S_L_ADDR: w_ns = S_L_WAIT;
      S_L_WAIT: w_ns = S_L_EVAL;
      S_L_EVAL: begin
        if (i_cap_hit) begin
          w_ns = S_OFS_WR;
        end else begin
          o_adj_wren = 1'b1;
          w_ns = (i_has_next && !i_guard_hit) ? S_L_ADDR : S_OFS_WR;
        end
      end
      S_OFS_WR: begin
        o_ofs_wren = 1'b1;
        w_ns = (i_cap_abort || i_last_node) ? S_DONE : S_H_ADDR;
      end
      S_DONE: begin
        if (!i_start_process) w_ns = S_IDLE;
      end
      default: w_ns = S_IDLE;
    endcase
  end

  assign o_cs = r_cs;
  assign o_ns = w_ns;

endmodule

// File: rtl/flatten_node_list_datapath.sv
// Counters, RAM field extraction and write-port drive for the flattening
// walk; all register updates are keyed off the controller's current state.
module flatten_node_list_datapath
  import flatten_node_list_pkg::*;
#(
  parameter int ADJ_AW  = 6,
  parameter int NODE_AW = 5
) (
  input  logic               clk,
  input  logic               i_program_reset,
  input  logic               i_start_process,
  input  logic [NODE_AW-1:0] i_num_nodes,
  input  logic [NODE_AW-1:0] i_num_elements,
  input  logic [63:0]        i_heads_out,
  input  logic [63:0]        i_links_out,
  input  state_t             i_cs,
  input  logic               i_adj_wren,
  input  logic               i_ofs_wren,
  output logic               o_start_rise,
  output logic               o_num_nodes_zero,
  output logic               o_head_valid,
  output logic               o_has_next,
  output logic               o_guard_hit,
  output logic               o_cap_hit,
  output logic               o_last_node,
  output logic               o_cap_abort,
  output logic [NODE_AW-1:0] o_heads_addr,
  output logic [NODE_AW-1:0] o_links_addr,
  output logic [NODE_AW-1:0] o_ofs_addr,
  output logic [ADJ_AW-1:0]  o_adj_addr,
  output logic [31:0]        o_adj_data,
  output logic [31:0]        o_ofs_data,
  output logic [ADJ_AW:0]    o_total_adj,
  output logic               o_flatten_error,
  output logic               o_end_process
);

  logic               r_start_d;
  logic [NODE_AW-1:0] r_node;
  logic [NODE_AW-1:0] r_link;
  logic [NODE_AW-1:0] r_num_nodes;
  logic [NODE_AW-1:0] r_num_elems;
  logic [ADJ_AW:0]    r_wr_ptr;
  logic [ADJ_AW:0]    r_total;
  logic [ADJ_AW:0]    r_count;
  logic [ADJ_AW-1:0]  r_start_ofs;
  logic               r_ovf;
  logic               r_error;
  logic               r_cap_abort;
  logic               r_end;

  logic               w_head_valid;
  logic [NODE_AW-1:0] w_head_ptr;
  logic               w_has_next;
  logic [NODE_AW-1:0] w_elem;
  logic [NODE_AW-1:0] w_next;
  logic [ADJ_AW:0]    w_count_inc;
  logic [ADJ_AW:0]    w_guard;
  logic               w_guard_hit;
  logic               w_cap_hit;
  logic               w_unused;

  assign w_head_valid = i_heads_out[VALID_BIT];
  assign w_head_ptr   = i_heads_out[PTR_LSB +: NODE_AW];
  assign w_has_next   = i_links_out[HAS_NEXT_BIT];
  assign w_elem       = i_links_out[ELEM_LSB +: NODE_AW];
  assign w_next       = i_links_out[PTR_LSB +: NODE_AW];
  assign w_unused     = ^{i_heads_out[VALID_BIT-1:PTR_LSB+NODE_AW],
                          i_links_out[HAS_NEXT_BIT-1:ELEM_LSB+NODE_AW],
                          i_links_out[ELEM_LSB-1:PTR_LSB+NODE_AW]};

  // A list longer than twice the element count can only be a cycle.
  assign w_count_inc = r_count + (ADJ_AW+1)'(1);
  assign w_guard     = (ADJ_AW+1)'({r_num_elems, 1'b0});
  assign w_guard_hit = (w_count_inc >= w_guard);
  assign w_cap_hit   = r_wr_ptr[ADJ_AW];

  always_ff @(posedge clk) begin
    if (i_program_reset) begin
      r_start_d   <= 1'b0;
      r_node      <= '0;
      r_link      <= '0;
      r_num_nodes <= '0;
      r_num_elems <= '0;
      r_wr_ptr    <= '0;
      r_total     <= '0;
      r_count     <= '0;
      r_start_ofs <= '0;
      r_ovf       <= 1'b0;
      r_error     <= 1'b0;
      r_cap_abort <= 1'b0;
      r_end       <= 1'b0;
    end else begin
      r_start_d <= i_start_process;
      r_end     <= (i_cs == S_DONE) && i_start_process;
      case (i_cs)
        S_IDLE: begin
          if (o_start_rise) begin
            r_node      <= '0;
            r_link      <= '0;
            r_wr_ptr    <= '0;
            r_total     <= '0;
            r_count     <= '0;
            r_start_ofs <= '0;
            r_ovf       <= 1'b0;
            r_cap_abort <= 1'b0;
            r_num_nodes <= i_num_nodes;
            r_num_elems <= i_num_elements;
          end
        end
        S_H_EVAL: begin
          r_start_ofs <= r_wr_ptr[ADJ_AW-1:0];
          r_count     <= '0;
          if (w_head_valid) r_link <= w_head_ptr;
        end
        S_L_EVAL: begin
          if (w_cap_hit) begin
            r_ovf       <= 1'b1;
            r_error     <= 1'b1;
            r_cap_abort <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + (ADJ_AW+1)'(1);
            r_total  <= r_wr_ptr + (ADJ_AW+1)'(1);
            r_count  <= w_count_inc;
            if (w_has_next) begin
              if (w_guard_hit) begin
                r_ovf   <= 1'b1;
                r_error <= 1'b1;
              end else begin
                r_link <= w_next;
              end
            end
          end
        end
        S_OFS_WR: begin
          r_node <= r_node + NODE_AW'(1);
          r_ovf  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_start_rise     = i_start_process & ~r_start_d;
  assign o_num_nodes_zero = (i_num_nodes == '0);
  assign o_head_valid     = w_head_valid;
  assign o_has_next       = w_has_next;
  assign o_guard_hit      = w_guard_hit;
  assign o_cap_hit        = w_cap_hit;
  assign o_last_node      = (r_node == r_num_nodes - NODE_AW'(1));
  assign o_cap_abort      = r_cap_abort;

  assign o_heads_addr = r_node;
  assign o_links_addr = r_link;
  assign o_ofs_addr   = r_node;
  assign o_adj_addr   = r_wr_ptr[ADJ_AW-1:0];
  assign o_adj_data   = i_adj_wren ? 32'(w_elem) : '0;
  assign o_ofs_data   = i_ofs_wren ?
                        pack_offset(OFS_START_W'(r_start_ofs), OFS_COUNT_W'(r_count), r_ovf) : '0;

  assign o_total_adj     = r_total;
  assign o_flatten_error = r_error;
  assign o_end_process   = r_end;

endmodule

// File: rtl/flatten_node_list.sv
// Stage 4 top: flattens per-node linked lists into a contiguous adjacency
// RAM plus one {start, count} descriptor per node.
module flatten_node_list
  import flatten_node_list_pkg::*;
#(
  parameter int ADJ_AW  = 6,
  parameter int NODE_AW = 5
) (
  input  logic               clk,
  input  logic               program_reset,
  input  logic               start_process,
  output logic               end_process,
  input  logic [NODE_AW-1:0] numNodes,
  input  logic [NODE_AW-1:0] numElements,
  output logic [NODE_AW-1:0] nodeHeads_addr,
  output logic               nodeHeads_wren,
  input  logic [63:0]        nodeHeads_out,
  output logic [NODE_AW-1:0] nodeToElement_addr,
  output logic               nodeToElement_wren,
  input  logic [63:0]        nodeToElement_out,
  output logic [ADJ_AW-1:0]  adj_addr,
  output logic [31:0]        adj_data,
  output logic               adj_wren,
  output logic [NODE_AW-1:0] nodeOffset_addr,
  output logic [31:0]        nodeOffset_data,
  output logic               nodeOffset_wren,
  output logic [ADJ_AW:0]    totalAdj,
  output logic               flatten_error,
  output logic [3:0]         cs,
  output logic [3:0]         ns
);

  state_t w_cs;
  state_t w_ns;
  logic   w_start_rise;
  logic   w_num_nodes_zero;
  logic   w_head_valid;
  logic   w_has_next;
  logic   w_guard_hit;
  logic   w_cap_hit;
  logic   w_last_node;
  logic   w_cap_abort;
  logic   w_adj_wren;
  logic   w_ofs_wren;

  flatten_node_list_controller u_ctrl (
    .clk              (clk),
    .i_program_reset  (program_reset),
    .i_start_process  (start_process),
    .i_start_rise     (w_start_rise),
    .i_num_nodes_zero (w_num_nodes_zero),
    .i_head_valid     (w_head_valid),
    .i_has_next       (w_has_next),
    .i_guard_hit      (w_guard_hit),
    .i_cap_hit        (w_cap_hit),
    .i_last_node      (w_last_node),
    .i_cap_abort      (w_cap_abort),
    .o_cs             (w_cs),
    .o_ns             (w_ns),
    .o_adj_wren       (w_adj_wren),
    .o_ofs_wren       (w_ofs_wren)
  );

  flatten_node_list_datapath #(
    .ADJ_AW  (ADJ_AW),
    .NODE_AW (NODE_AW)
  ) u_dp (
    .clk              (clk),
    .i_program_reset  (program_reset),
    .i_start_process  (start_process),
    .i_num_nodes      (numNodes),
    .i_num_elements   (numElements),
    .i_heads_out      (nodeHeads_out),
    .i_links_out      (nodeToElement_out),
    .i_cs             (w_cs),
    .i_adj_wren       (w_adj_wren),
    .i_ofs_wren       (w_ofs_wren),
    .o_start_rise     (w_start_rise),
    .o_num_nodes_zero (w_num_nodes_zero),
    .o_head_valid     (w_head_valid),
    .o_has_next       (w_has_next),
    .o_guard_hit      (w_guard_hit),
    .o_cap_hit        (w_cap_hit),
    .o_last_node      (w_last_node),
    .o_cap_abort      (w_cap_abort),
    .o_heads_addr     (nodeHeads_addr),
    .o_links_addr     (nodeToElement_addr),
    .o_ofs_addr       (nodeOffset_addr),
    .o_adj_addr       (adj_addr),
    .o_adj_data       (adj_data),
    .o_ofs_data       (nodeOffset_data),
    .o_total_adj      (totalAdj),
    .o_flatten_error  (flatten_error),
    .o_end_process    (end_process)
  );

  assign nodeHeads_wren     = 1'b0;
  assign nodeToElement_wren = 1'b0;
  assign adj_wren           = w_adj_wren;
  assign nodeOffset_wren    = w_ofs_wren;
  assign cs                 = w_cs;
  assign ns                 = w_ns;

endmodule

// File: tb/tb_flatten_node_list.sv
// Scenario bench for flatten_node_list: a behavioural list walker fills
// expected-write queues that are drained as the DUT strobes its RAM ports.
module tb_flatten_node_list;
  import flatten_node_list_pkg::*;

  logic        clk = 1'b0;
  logic        program_reset;
  logic        start_process;
  logic        end_process;
  logic [4:0]  numNodes;
  logic [4:0]  numElements;
  logic [4:0]  nodeHeads_addr;
  logic        nodeHeads_wren;
  logic [63:0] nodeHeads_out;
  logic [4:0]  nodeToElement_addr;
  logic        nodeToElement_wren;
  logic [63:0] nodeToElement_out;
  logic [5:0]  adj_addr;
  logic [31:0] adj_data;
  logic        adj_wren;
  logic [4:0]  nodeOffset_addr;
  logic [31:0] nodeOffset_data;
  logic        nodeOffset_wren;
  logic [6:0]  totalAdj;
  logic        flatten_error;
  logic [3:0]  cs;
  logic [3:0]  ns;

  logic [63:0] heads_mem [32];
  logic [63:0] links_mem [32];
  logic [37:0] adj_q [$];
  logic [36:0] ofs_q [$];
  logic [6:0]  exp_total;
  logic        exp_err;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    nodeHeads_out     <= heads_mem[nodeHeads_addr];
    nodeToElement_out <= links_mem[nodeToElement_addr];
  end

  flatten_node_list dut (
    .clk                (clk),
    .program_reset      (program_reset),
    .start_process      (start_process),
    .end_process        (end_process),
    .numNodes           (numNodes),
    .numElements        (numElements),
    .nodeHeads_addr     (nodeHeads_addr),
    .nodeHeads_wren     (nodeHeads_wren),
    .nodeHeads_out      (nodeHeads_out),
    .nodeToElement_addr (nodeToElement_addr),
    .nodeToElement_wren (nodeToElement_wren),
    .nodeToElement_out  (nodeToElement_out),
    .adj_addr           (adj_addr),
    .adj_data           (adj_data),
    .adj_wren           (adj_wren),
    .nodeOffset_addr    (nodeOffset_addr),
    .nodeOffset_data    (nodeOffset_data),
    .nodeOffset_wren    (nodeOffset_wren),
    .totalAdj           (totalAdj),
    .flatten_error      (flatten_error),
    .cs                 (cs),
    .ns                 (ns)
  );

  function automatic logic [63:0] mk_head(input logic valid, input logic [4:0] head);
    return {valid, 58'b0, head};
  endfunction

  function automatic logic [63:0] mk_link(input logic nxt, input logic [4:0] elem,
                                          input logic [4:0] next);
    return {nxt, 26'b0, elem, 27'b0, next};
  endfunction

  // Advance one clock and drain any write strobes against the scoreboard.
  task automatic tick();
    logic [37:0] ea;
    logic [36:0] eo;
    @(posedge clk);
    #1;
    if (adj_wren) begin
      n_vec++;
      if (nodeOffset_wren) begin
        n_err++;
        $display("FAIL wr_excl: adj_wren=1 nodeOffset_wren=1, required not both");
      end
      if (adj_q.size() == 0) begin
        n_err++;
        $display("FAIL adj_unexpected: addr=%0d data=%0h, required no write", adj_addr, adj_data);
      end else begin
        ea = adj_q.pop_front();
        if ({adj_addr, adj_data} !== ea) begin
          n_err++;
          $display("FAIL adj_write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   adj_addr, adj_data, ea[37:32], ea[31:0]);
        end
      end
    end
    if (nodeOffset_wren) begin
      n_vec++;
      if (ofs_q.size() == 0) begin
        n_err++;
        $display("FAIL ofs_unexpected: addr=%0d data=%0h, required no write",
                 nodeOffset_addr, nodeOffset_data);
      end else begin
        eo = ofs_q.pop_front();
        if ({nodeOffset_addr, nodeOffset_data} !== eo) begin
          n_err++;
          $display("FAIL ofs_write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   nodeOffset_addr, nodeOffset_data, eo[36:32], eo[31:0]);
        end
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      heads_mem[i] = '0;
      links_mem[i] = '0;
    end
  endtask

  task automatic apply_reset();
    program_reset = 1'b1;
    start_process = 1'b0;
    adj_q.delete();
    ofs_q.delete();
    tick();
    tick();
    program_reset = 1'b0;
    exp_err = 1'b0;
    tick();
  endtask

  // Behavioural walk of the list RAMs producing the expected write stream.
  task automatic build_model(input int nn, input int ne);
    int          wp;
    int          cnt;
    int          link;
    logic        ovf;
    logic        abort;
    logic [5:0]  st;
    logic [63:0] w;
    adj_q.delete();
    ofs_q.delete();
    wp = 0;
    abort = 1'b0;
    for (int n = 0; n < nn && !abort; n++) begin
      st  = wp[5:0];
      cnt = 0;
      ovf = 1'b0;
      if (heads_mem[n][63]) begin
        link = int'(heads_mem[n][4:0]);
        for (int s = 0; s < 80; s++) begin
          w = links_mem[link];
          if (wp == 64) begin
            ovf = 1'b1; exp_err = 1'b1; abort = 1'b1;
            break;
          end
          adj_q.push_back({6'(wp), 27'b0, w[36:32]});
          wp++;
          cnt++;
          if (!w[63]) break;
          if (cnt >= 2 * ne) begin
            ovf = 1'b1; exp_err = 1'b1;
            break;
          end
          link = int'(w[4:0]);
        end
      end
      ofs_q.push_back({5'(n), ovf, 9'b0, 6'(cnt), 10'b0, st});
    end
    exp_total = 7'(wp);
  endtask

  task automatic run_pass(input int nn, input int ne, input int exp_cycles, input bit keep_start);
    int cyc;
    numNodes    = 5'(nn);
    numElements = 5'(ne);
    build_model(nn, ne);
    start_process = 1'b1;
    cyc = 0;
    while (!end_process && cyc < 2000) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (!end_process) begin
      n_err++;
      $display("FAIL done_timeout: end_process=0 after %0d cycles, required 1", cyc);
    end
    n_vec++;
    if (cyc != exp_cycles) begin
      n_err++;
      $display("FAIL latency: end_process after %0d cycles, required %0d", cyc, exp_cycles);
    end
    n_vec++;
    if (adj_q.size() != 0 || ofs_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_writes: pending adj=%0d ofs=%0d, required 0 0", adj_q.size(), ofs_q.size());
    end
    n_vec++;
    if (totalAdj !== exp_total) begin
      n_err++;
      $display("FAIL total_adj: got %0d, required %0d", totalAdj, exp_total);
    end
    n_vec++;
    if (flatten_error !== exp_err) begin
      n_err++;
      $display("FAIL flatten_error: got %0b, required %0b", flatten_error, exp_err);
    end
    if (!keep_start) begin
      start_process = 1'b0;
      tick();
      tick();
      n_vec++;
      if (end_process !== 1'b0 || cs !== S_IDLE) begin
        n_err++;
        $display("FAIL release: end_process=%0b cs=%0d, required 0 and %0d", end_process, cs, S_IDLE);
      end
    end
  endtask

  task automatic setup_two_nodes();
    clear_mem();
    heads_mem[0] = mk_head(1'b1, 5'd0);
    heads_mem[1] = mk_head(1'b1, 5'd2);
    links_mem[0] = mk_link(1'b1, 5'd0, 5'd1);
    links_mem[1] = mk_link(1'b0, 5'd2, 5'd0);
    links_mem[2] = mk_link(1'b0, 5'd0, 5'd0);
  endtask

  task automatic test_reset();
    program_reset = 1'b1;
    start_process = 1'b0;
    numNodes      = '0;
    numElements   = '0;
    clear_mem();
    tick();
    tick();
    n_vec++;
    if ({nodeHeads_addr, nodeToElement_addr, adj_addr, nodeOffset_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_addr: heads=%0d links=%0d adj=%0d ofs=%0d, required all 0",
               nodeHeads_addr, nodeToElement_addr, adj_addr, nodeOffset_addr);
    end
    n_vec++;
    if ({nodeHeads_wren, nodeToElement_wren, adj_wren, nodeOffset_wren} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_wren: got %b, required 0000",
               {nodeHeads_wren, nodeToElement_wren, adj_wren, nodeOffset_wren});
    end
    n_vec++;
    if ({totalAdj, flatten_error, end_process} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_status: totalAdj=%0d err=%0b end=%0b, required 0 0 0",
               totalAdj, flatten_error, end_process);
    end
    n_vec++;
    if (cs !== S_IDLE || ns !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: cs=%0d ns=%0d, required %0d", cs, ns, S_IDLE);
    end
    program_reset = 1'b0;
    exp_err = 1'b0;
    tick();
  endtask

  task automatic test_two_nodes();
    setup_two_nodes();
    apply_reset();
    run_pass(2, 3, 19, 1'b0);
  endtask

  task automatic test_invalid_head();
    clear_mem();
    heads_mem[0] = mk_head(1'b1, 5'd0);
    heads_mem[1] = mk_head(1'b0, 5'd7);
    heads_mem[2] = mk_head(1'b1, 5'd2);
    links_mem[0] = mk_link(1'b1, 5'd0, 5'd1);
    links_mem[1] = mk_link(1'b0, 5'd2, 5'd0);
    links_mem[2] = mk_link(1'b0, 5'd0, 5'd0);
    apply_reset();
    run_pass(3, 3, 23, 1'b0);
  endtask

  task automatic test_zero_nodes();
    setup_two_nodes();
    apply_reset();
    run_pass(0, 3, 2, 1'b0);
  endtask

  task automatic test_cyclic();
    clear_mem();
    heads_mem[0] = mk_head(1'b1, 5'd3);
    heads_mem[1] = mk_head(1'b1, 5'd4);
    links_mem[3] = mk_link(1'b1, 5'd1, 5'd3);
    links_mem[4] = mk_link(1'b0, 5'd0, 5'd0);
    apply_reset();
    run_pass(2, 2, 25, 1'b0);
  endtask

  task automatic test_capacity();
    clear_mem();
    heads_mem[0] = mk_head(1'b1, 5'd5);
    heads_mem[1] = mk_head(1'b1, 5'd6);
    heads_mem[2] = mk_head(1'b1, 5'd7);
    links_mem[5] = mk_link(1'b1, 5'd3, 5'd5);
    links_mem[6] = mk_link(1'b1, 5'd4, 5'd6);
    links_mem[7] = mk_link(1'b0, 5'd9, 5'd0);
    apply_reset();
    run_pass(3, 31, 205, 1'b0);
  endtask

  task automatic test_reset_mid_walk();
    int cyc;
    setup_two_nodes();
    apply_reset();
    numNodes    = 5'd2;
    numElements = 5'd3;
    build_model(2, 3);
    start_process = 1'b1;
    cyc = 0;
    while (cs !== S_L_WAIT && cyc < 50) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cs !== S_L_WAIT) begin
      n_err++;
      $display("FAIL reach_l_wait: cs=%0d after %0d cycles, required %0d", cs, cyc, S_L_WAIT);
    end
    program_reset = 1'b1;
    start_process = 1'b0;
    adj_q.delete();
    ofs_q.delete();
    tick();
    n_vec++;
    if ({adj_wren, nodeOffset_wren} !== 2'b00 || cs !== S_IDLE || totalAdj !== 7'd0) begin
      n_err++;
      $display("FAIL mid_reset: adj_wren=%0b ofs_wren=%0b cs=%0d totalAdj=%0d, required 0 0 %0d 0",
               adj_wren, nodeOffset_wren, cs, totalAdj, S_IDLE);
    end
    program_reset = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    run_pass(2, 3, 19, 1'b0);
  endtask

  task automatic test_back_to_back();
    setup_two_nodes();
    apply_reset();
    run_pass(2, 3, 19, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    n_vec++;
    if (cs !== S_DONE || end_process !== 1'b1) begin
      n_err++;
      $display("FAIL hold_start: cs=%0d end_process=%0b, required %0d 1", cs, end_process, S_DONE);
    end
    start_process = 1'b0;
    tick();
    tick();
    n_vec++;
    if (cs !== S_IDLE) begin
      n_err++;
      $display("FAIL rearm: cs=%0d, required %0d", cs, S_IDLE);
    end
    run_pass(2, 3, 19, 1'b0);
  endtask

  initial begin
    test_reset();
    test_two_nodes();
    test_invalid_head();
    test_zero_nodes();
    test_cyclic();
    test_capacity();
    test_reset_mid_walk();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
